// File: rtl/io_axil_bridge_pkg.sv
// ---------------------------------------------------------------------------
// io_axil_bridge_pkg
//   Shared AXI4-Lite definitions for the IO-bus to AXI4-Lite bridge:
//   response codes, bridge FSM state encodings, the default protection
//   value and a response classification helper.
// ---------------------------------------------------------------------------
package io_axil_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_WRESP = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_RRESP = 3'd4;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  // Anything other than OKAY (including EXOKAY, which a non-exclusive
  // access should never see) is treated as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/io_axil_bridge.sv
// ---------------------------------------------------------------------------
// io_axil_bridge
//   Converts the soft CPU's single-beat IO bus into an AXI4-Lite master.
//   One transaction in flight. AW and W are driven independently and each
//   drops the cycle after its own handshake. Non-OKAY responses and watchdog
//   expiry raise a sticky error flag and capture the first failing address;
//   a strobe arriving while busy is discarded and flagged as an overrun.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   io_addr_strobe             1-cycle request pulse
//   io_read_strobe/_write_     request type (exactly one must be set)
//   io_addr, io_byte_enable,   request address, write strobes, write data
//   io_write_data
//   io_read_data, io_ready     read data and 1-cycle completion pulse
//   m_aw*, m_w*, m_b*          AXI4-Lite write address / data / response
//   m_ar*, m_r*                AXI4-Lite read address / data
//   err_flag, err_addr         sticky error flag, address of first error
//   overrun_flag               sticky "strobe while busy" flag
//   err_clear                  clears err_flag and overrun_flag
// ---------------------------------------------------------------------------
module io_axil_bridge
  import io_axil_bridge_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  io_addr_strobe,
  input  logic                  io_read_strobe,
  input  logic                  io_write_strobe,
  input  logic [31:0]           io_addr,
  input  logic [3:0]            io_byte_enable,
  input  logic [31:0]           io_write_data,
  output logic [31:0]           io_read_data,
  output logic                  io_ready,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [31:0]           m_rdata,
  input  logic [1:0]            m_rresp,
  output logic                  err_flag,
  output logic [31:0]           err_addr,
  output logic                  overrun_flag,
  input  logic                  err_clear
);

  // The timer holds "cycles since the request" and fires one cycle early so
  // that io_ready lands exactly TIMEOUT_CYCLES after the strobe.
  localparam int TMR_W      = (TIMEOUT_CYCLES < 2) ? 2 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int TMR_LAST_I = (TIMEOUT_CYCLES < 2) ? 1 : TIMEOUT_CYCLES - 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_LAST_I[TMR_W-1:0];
  localparam bit WDOG_EN    = (TIMEOUT_CYCLES != 0);

  logic [2:0]       state;
  logic [31:0]      req_addr;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [TMR_W-1:0] timer;

  logic req_wr, req_rd, busy;
  logic b_done, r_done, timeout;
  logic err_set, overrun_set;

  // Requests with both or neither type bit set are dropped silently.
  assign req_wr  = io_addr_strobe &  io_write_strobe & ~io_read_strobe;
  assign req_rd  = io_addr_strobe &  io_read_strobe  & ~io_write_strobe;
  assign busy    = (state != ST_IDLE);
  assign b_done  = (state == ST_WRESP) & m_bvalid;
  assign r_done  = (state == ST_RRESP) & m_rvalid;

  // A response landing on the expiry cycle completes normally.
  assign timeout = WDOG_EN & busy & ~b_done & ~r_done & (timer == TMR_LAST);

  assign err_set = (b_done & resp_is_err(m_bresp))
                 | (r_done & resp_is_err(m_rresp))
                 | timeout;
  assign overrun_set = io_addr_strobe & busy;

  assign m_awaddr = req_addr[ADDR_WIDTH-1:0];
  assign m_araddr = req_addr[ADDR_WIDTH-1:0];
  assign m_wdata  = wdata_q;
  assign m_wstrb  = wstrb_q;
  assign m_awprot = PROT_DEFAULT;
  assign m_arprot = PROT_DEFAULT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      req_addr     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      timer        <= '0;
      m_awvalid    <= 1'b0;
      m_wvalid     <= 1'b0;
      m_bready     <= 1'b0;
      m_arvalid    <= 1'b0;
      m_rready     <= 1'b0;
      io_ready     <= 1'b0;
      io_read_data <= '0;
    end else begin
      io_ready <= 1'b0;
      if (busy) timer <= timer + TMR_W'(1);

      case (state)
        ST_IDLE: begin
          if (req_wr) begin
            state     <= ST_WRITE;
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
            req_addr  <= io_addr;
            wdata_q   <= io_write_data;
            wstrb_q   <= io_byte_enable;
            timer     <= TMR_W'(1);
          end else if (req_rd) begin
            state     <= ST_READ;
            m_arvalid <= 1'b1;
            req_addr  <= io_addr;
            timer     <= TMR_W'(1);
          end
        end
        ST_WRITE: begin
          // Each channel retires on its own handshake; a channel already
          // retired has its valid low and counts as done.
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready)  m_wvalid  <= 1'b0;
          if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
            state    <= ST_WRESP;
            m_bready <= 1'b1;
          end
        end
        ST_WRESP: begin
          if (m_bvalid) begin
            m_bready <= 1'b0;
            io_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= ST_RRESP;
          end
        end
        ST_RRESP: begin
          if (m_rvalid) begin
            m_rready     <= 1'b0;
            io_read_data <= resp_is_err(m_rresp) ? TIMEOUT_DATA : m_rdata;
            io_ready     <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Forced completion: abandon the AXI transaction outright. Any late
      // response from the slave is simply ignored.
      if (timeout) begin
        m_awvalid    <= 1'b0;
        m_wvalid     <= 1'b0;
        m_bready     <= 1'b0;
        m_arvalid    <= 1'b0;
        m_rready     <= 1'b0;
        io_ready     <= 1'b1;
        io_read_data <= TIMEOUT_DATA;
        state        <= ST_IDLE;
      end
    end
  end

  // Sticky status; a new event in the same cycle as err_clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag     <= 1'b0;
      err_addr     <= '0;
      overrun_flag <= 1'b0;
    end else begin
      if (err_set)        err_flag <= 1'b1;
      else if (err_clear) err_flag <= 1'b0;

      if (err_set && !err_flag) err_addr <= req_addr;

      if (overrun_set)    overrun_flag <= 1'b1;
      else if (err_clear) overrun_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_axil_bridge.sv
// ---------------------------------------------------------------------------
// tb_io_axil_bridge
//   Directed bench for io_axil_bridge. Requests push their expected
//   completion (read data and latency in cycles) into a scoreboard; a
//   monitor pops and compares on every io_ready pulse. A configurable
//   AXI4-Lite slave counts handshakes and captures address/data.
// ---------------------------------------------------------------------------
module tb_io_axil_bridge;

  logic        clk;
  logic        rst_n;
  logic        io_addr_strobe, io_read_strobe, io_write_strobe;
  logic [31:0] io_addr, io_write_data, io_read_data;
  logic [3:0]  io_byte_enable;
  logic        io_ready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;
  logic        err_flag, overrun_flag, err_clear;
  logic [31:0] err_addr;

  io_axil_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
    .io_write_strobe(io_write_strobe), .io_addr(io_addr),
    .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .io_ready(io_ready),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .err_flag(err_flag), .err_addr(err_addr), .overrun_flag(overrun_flag),
    .err_clear(err_clear)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    if (act === exp) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    bit          is_read;
    logic [31:0] data;
    int          start;
    int          lat;
  } exp_t;
  exp_t sb[$];

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && io_ready) begin
      if (sb.size() == 0) begin
        total_cnt = total_cnt + 1;
        $display("FAIL unexpected_io_ready: got io_ready=1 at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        if (e.is_read) check("read_data", io_read_data, e.data);
        check("latency", cyc - e.start, e.lat);
      end
    end
  end

  // ---------------- AXI4-Lite slave ----------------
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  bit b_never;
  logic [1:0]  b_resp_cfg, r_resp_cfg;
  logic [31:0] r_data_cfg;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int aw_hs, w_hs, b_hs, ar_hs;
  bit aw_got, w_got, b_pend, r_pend;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;

  task automatic slave_cfg(input int aw, input int w, input int b, input int ar, input int r,
                           input bit bnever, input logic [1:0] bresp, input logic [1:0] rresp,
                           input logic [31:0] rdata);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r; b_never = bnever;
    b_resp_cfg = bresp; r_resp_cfg = rresp; r_data_cfg = rdata;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
    m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
  endtask

  // Outputs are decided at the negedge for the following posedge, so a
  // handshake is known (and counted) when it is scheduled.
  initial forever begin
    @(negedge clk);
    if (b_pend) begin
      if (b_cnt >= b_dly && !b_never) begin
        m_bvalid = 1; m_bresp = b_resp_cfg;
        if (m_bready) begin b_pend = 0; b_hs = b_hs + 1; end
      end else begin
        m_bvalid = 0; if (!b_never) b_cnt = b_cnt + 1;
      end
    end else m_bvalid = 0;

    if (r_pend) begin
      if (r_cnt >= r_dly) begin
        m_rvalid = 1; m_rresp = r_resp_cfg; m_rdata = r_data_cfg;
        if (m_rready) r_pend = 0;
      end else begin
        m_rvalid = 0; r_cnt = r_cnt + 1;
      end
    end else m_rvalid = 0;

    if (m_awvalid) begin
      if (aw_cnt >= aw_dly) begin
        m_awready = 1; aw_hs = aw_hs + 1; aw_got = 1; aw_cnt = 0; cap_awaddr = m_awaddr;
      end else begin m_awready = 0; aw_cnt = aw_cnt + 1; end
    end else begin m_awready = 0; aw_cnt = 0; end

    if (m_wvalid) begin
      if (w_cnt >= w_dly) begin
        m_wready = 1; w_hs = w_hs + 1; w_got = 1; w_cnt = 0;
        cap_wdata = m_wdata; cap_wstrb = m_wstrb;
      end else begin m_wready = 0; w_cnt = w_cnt + 1; end
    end else begin m_wready = 0; w_cnt = 0; end

    if (m_arvalid) begin
      if (ar_cnt >= ar_dly) begin
        m_arready = 1; ar_hs = ar_hs + 1; ar_cnt = 0; cap_araddr = m_araddr;
        r_pend = 1; r_cnt = 0;
      end else begin m_arready = 0; ar_cnt = ar_cnt + 1; end
    end else begin m_arready = 0; ar_cnt = 0; end

    if (aw_got && w_got) begin
      aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit expect_done, input logic [31:0] exp_rd,
                       input int lat);
    @(negedge clk);
    io_addr_strobe = 1; io_read_strobe = rd; io_write_strobe = wr;
    io_addr = a; io_write_data = d; io_byte_enable = be;
    if (expect_done) sb.push_back('{rd, exp_rd, cyc, lat});
    @(negedge clk);
    io_addr_strobe = 0; io_read_strobe = 0; io_write_strobe = 0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 64) begin
      @(negedge clk);
      n = n + 1;
    end
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic pulse_clear();
    @(negedge clk); err_clear = 1;
    @(negedge clk); err_clear = 0;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; err_clear = 0;
    io_addr_strobe = 0; io_read_strobe = 0; io_write_strobe = 0;
    io_addr = '0; io_write_data = '0; io_byte_enable = '0;
    slave_cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_valids", {26'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, io_ready}, 32'd0);
    check("rst_rdata", io_read_data, 32'd0);
    check("rst_flags", {30'd0, err_flag, overrun_flag}, 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    check("prot", {26'd0, m_awprot, m_arprot}, 32'd0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Minimum-latency write
    slave_cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    issue(0, 1, 32'h0000_1100, 32'h0102_0304, 4'hF, 1, 32'h0, 3);
    wait_done("wr_min_done");
    check("wr_min_aw_hs", aw_hs, 1);
    check("wr_min_awaddr", cap_awaddr, 32'h0000_1100);
    check("wr_min_wdata", cap_wdata, 32'h0102_0304);
    check("wr_min_err", {31'd0, err_flag}, 32'd0);

    // Write with AW accepted two cycles before W
    slave_cfg(0, 2, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    issue(0, 1, 32'h0000_1000, 32'hA5A5_5A5A, 4'b0011, 1, 32'h0, 5);
    wait_done("wr_split_done");
    repeat (5) @(negedge clk);
    check("wr_split_aw_hs", aw_hs, 1);
    check("wr_split_w_hs", w_hs, 1);
    check("wr_split_b_hs", b_hs, 1);
    check("wr_split_awaddr", cap_awaddr, 32'h0000_1000);
    check("wr_split_wdata", cap_wdata, 32'hA5A5_5A5A);
    check("wr_split_wstrb", {28'd0, cap_wstrb}, 32'h3);
    check("wr_split_idle", {29'd0, m_awvalid, m_wvalid, m_bready}, 32'd0);

    // Read with delayed rvalid
    slave_cfg(0, 0, 0, 0, 5, 0, 2'b00, 2'b00, 32'h1234_5678);
    issue(1, 0, 32'h0000_2004, 32'h0, 4'h0, 1, 32'h1234_5678, 8);
    wait_done("rd_done");
    check("rd_araddr", cap_araddr, 32'h0000_2004);
    check("rd_ar_hs", ar_hs, 1);
    check("rd_err", {31'd0, err_flag}, 32'd0);
    check("rd_idle", {30'd0, m_arvalid, m_rready}, 32'd0);

    // Error responses: first error address is kept
    slave_cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 32'h5555_AAAA);
    issue(1, 0, 32'h0000_3000, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 3);
    wait_done("slverr_done");
    check("slverr_flag", {31'd0, err_flag}, 32'd1);
    check("slverr_addr", err_addr, 32'h0000_3000);
    slave_cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 32'h5555_AAAA);
    issue(1, 0, 32'h0000_4000, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 3);
    wait_done("decerr_done");
    check("decerr_addr_kept", err_addr, 32'h0000_3000);
    pulse_clear();
    check("clear_flag", {31'd0, err_flag}, 32'd0);
    check("clear_addr_kept", err_addr, 32'h0000_3000);

    // Watchdog: slave never returns bvalid
    slave_cfg(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 32'h0);
    issue(0, 1, 32'h0000_5000, 32'h1111_2222, 4'hF, 1, 32'h0, 16);
    wait_done("timeout_done");
    check("timeout_idle", {27'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 32'd0);
    check("timeout_flag", {31'd0, err_flag}, 32'd1);
    check("timeout_addr", err_addr, 32'h0000_5000);
    slave_cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    pulse_clear();

    // Overrun: strobe during RRESP is discarded
    slave_cfg(0, 0, 0, 0, 4, 0, 2'b00, 2'b00, 32'h0BAD_F00D);
    issue(1, 0, 32'h0000_6000, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 7);
    @(negedge clk);
    issue(1, 0, 32'h0000_7000, 32'h0, 4'h0, 0, 32'h0, 0);
    wait_done("overrun_done");
    repeat (3) @(negedge clk);
    check("overrun_flag", {31'd0, overrun_flag}, 32'd1);
    check("overrun_ar_hs", ar_hs, 1);
    check("overrun_araddr", cap_araddr, 32'h0000_6000);
    check("overrun_no_err", {31'd0, err_flag}, 32'd0);
    pulse_clear();
    check("overrun_clear", {31'd0, overrun_flag}, 32'd0);

    // Malformed requests are ignored
    slave_cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    issue(1, 1, 32'h0000_7100, 32'h0, 4'hF, 0, 32'h0, 0);
    issue(0, 0, 32'h0000_7200, 32'h0, 4'hF, 0, 32'h0, 0);
    repeat (6) @(negedge clk);
    check("ignored_hs", aw_hs + ar_hs + w_hs, 0);
    check("ignored_flags", {30'd0, err_flag, overrun_flag}, 32'd0);

    // Asynchronous reset mid-write, then a normal read
    slave_cfg(20, 20, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    issue(0, 1, 32'h0000_9000, 32'h3333_4444, 4'hF, 0, 32'h0, 0);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("async_rst_valids", {30'd0, m_awvalid, m_wvalid}, 32'd0);
    slave_cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hCAFE_F00D);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    issue(1, 0, 32'h0000_8000, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 3);
    wait_done("post_rst_done");
    check("post_rst_araddr", cap_araddr, 32'h0000_8000);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
